// File: rtl/timer_irq_ctrl.sv
// Memory-mapped reload timer with a request/acknowledge/clear interrupt sequencer.
// Define TIMER_IRQ_COUNT_EN to add the read-only ICNT acknowledge counter at +C.
module timer_irq_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  input  logic        mem_read,
  input  logic        mem_write,
  output logic [31:0] rd_data,
  output logic        hit,
  output logic        irq,
  input  logic        irq_ack
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;
`ifdef TIMER_IRQ_COUNT_EN
  localparam logic ICNT_IMPL = 1'b1;
`else
  localparam logic ICNT_IMPL = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, PEND, SERV} state_t;

  state_t          state, state_nx;
  logic [31:0]     th, tl, rd_mux;
  logic            en, ie, st, ovr;
  logic [PW-1:0]   pre;
  logic            wr, th_wr, tl_wr, tcon_wr, tick, ovf;
  logic            st_set, st_clr, ovr_set, ovr_clr, st_nx, ovr_nx;
  logic [1:0]      unused_addr;

  assign unused_addr = addr[1:0];

  // Decode: +C only answers when the counter is built in
  assign hit     = (addr[31:4] == BASE_ADDR[31:4]) && ((addr[3:2] != 2'd3) || ICNT_IMPL);
  assign wr      = mem_write && hit;
  assign th_wr   = wr && (addr[3:2] == 2'd0);
  assign tl_wr   = wr && (addr[3:2] == 2'd1);
  assign tcon_wr = wr && (addr[3:2] == 2'd2);

  // A software write to TL suppresses any overflow on the same edge
  assign tick    = en && (pre == PW'(PRESCALE - 1));
  assign ovf     = tick && (tl == ALL_ONES) && !tl_wr;
  assign st_set  = ovf && ie;
  assign st_clr  = tcon_wr && wr_data[2];
  assign ovr_set = st_set && (state == SERV) && !st_clr;
  assign ovr_clr = tcon_wr && wr_data[3];
  assign st_nx   = st_set | (st & ~st_clr);
  assign ovr_nx  = ovr_set | (ovr & ~ovr_clr);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (st_nx) state_nx = PEND;
      PEND:    if (!st_nx) state_nx = IDLE;
               else if (irq_ack) state_nx = SERV;
      SERV:    if (!st_nx) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      irq   <= 1'b0;
    end else begin
      state <= state_nx;
      irq   <= (state_nx == PEND);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th  <= '0;
      tl  <= '0;
      en  <= 1'b0;
      ie  <= 1'b0;
      st  <= 1'b0;
      ovr <= 1'b0;
      pre <= '0;
    end else begin
      if (th_wr) th <= wr_data;
      if (tl_wr)     tl <= wr_data;
      else if (ovf)  tl <= th;
      else if (tick) tl <= tl + 32'd1;
      if (tcon_wr) begin
        en <= wr_data[0];
        ie <= wr_data[1];
      end
      st  <= st_nx;
      ovr <= ovr_nx;
      if (tl_wr || (tcon_wr && !wr_data[0])) pre <= '0;
      else if (tick)                         pre <= '0;
      else if (en)                           pre <= pre + PW'(1);
    end
  end

`ifdef TIMER_IRQ_COUNT_EN
  logic [31:0] icnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) icnt <= '0;
    else if ((state == PEND) && (state_nx == SERV)) icnt <= icnt + 32'd1;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (addr[3:2])
      2'd0: rd_mux = th;
      2'd1: rd_mux = tl;
      2'd2: rd_mux = {28'd0, ovr, st, ie, en};
`ifdef TIMER_IRQ_COUNT_EN
      2'd3: rd_mux = icnt;
`else
      2'd3: rd_mux = '0;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= (mem_read && hit) ? rd_mux : '0;
  end

endmodule
